memory_system: RTL and testbench

- Data-memory subsystem for the pipelined 16-bit processor.
- Contains a 2-way set-associative, write-through, write-allocate cache in front of a pipelined main memory.
- Serves one word access per cycle on a hit.
- Raises cache_miss_stall to freeze the pipeline while a missing block is filled.

---
 rtl/memory_system_pkg.sv | 21 ++
 rtl/memory_system_main_memory.sv | 43 ++++
 rtl/memory_system.sv | 161 ++++++++++++++++
 tb/tb_memory_system.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/memory_system_pkg.sv
// Shared constants and FSM state type for the data-memory subsystem
// (2-way set-associative write-through cache over a pipelined main memory).
package memory_system_pkg;

    localparam int BLOCK_WORDS = 8;
    localparam int NUM_SETS    = 32;
    localparam int NUM_WAYS    = 2;
    localparam int MEM_LATENCY = 4;
    localparam int TAG_W       = 7;
    localparam int INDEX_W     = 5;
    localparam int OFFSET_W    = 3;

    // Last fill cycle: word 7 is requested on cycle 7 and lands on cycle 11.
    localparam int FILL_LAST   = BLOCK_WORDS + MEM_LATENCY - 1;

    typedef enum logic {
        IDLE,
        FILL
    } state_e;

endpackage

// File: rtl/memory_system_main_memory.sv
// Single-port word memory: 1-cycle write, read data appears MEM_LATENCY
// cycles after the address is presented. Contents survive reset.
module main_memory
    import memory_system_pkg::*;
#(
    parameter int DWIDTH    = 16,
    parameter int MEM_WORDS = 32768,
    parameter int MAW       = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [MAW-1:0]    addr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    output logic [DWIDTH-1:0] rdata_o
);

    logic [DWIDTH-1:0] mem_q  [MEM_WORDS];
    logic [DWIDTH-1:0] pipe_q [MEM_LATENCY];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Stage 0 is the registered array read; the rest only add latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < MEM_LATENCY; s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            pipe_q[0] <= mem_q[addr_i];
            for (int s = 1; s < MEM_LATENCY; s++) begin
                pipe_q[s] <= pipe_q[s-1];
            end
        end
    end

    assign rdata_o = pipe_q[MEM_LATENCY-1];

endmodule

// File: rtl/memory_system.sv
// Data-memory subsystem: 2-way set-associative, write-through, write-allocate
// cache with a 12-cycle block fill from pipelined main memory.
module memory_system
    import memory_system_pkg::*;
#(
    parameter int AWIDTH    = 16,
    parameter int DWIDTH    = 16,
    parameter int MEM_WORDS = 32768
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic              mem_write,
    input  logic [AWIDTH-1:0] addr_in,
    input  logic [DWIDTH-1:0] data_in,
    output logic [DWIDTH-1:0] data_out,
    output logic              cache_miss_stall
);

    localparam int MAW = AWIDTH - 1;

    logic [TAG_W-1:0]    tag_w;
    logic [INDEX_W-1:0]  idx_w;
    logic [OFFSET_W-1:0] off_w;
    logic                unused_addr_bit;

    assign tag_w           = addr_in[AWIDTH-1 -: TAG_W];
    assign idx_w           = addr_in[OFFSET_W+INDEX_W -: INDEX_W];
    assign off_w           = addr_in[OFFSET_W:1];
    assign unused_addr_bit = addr_in[0];

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [TAG_W-1:0]    fill_tag_q, fill_tag_d;
    logic [INDEX_W-1:0]  fill_idx_q, fill_idx_d;
    logic                victim_q, victim_d;

    logic [DWIDTH-1:0]   data_q  [NUM_WAYS][NUM_SETS*BLOCK_WORDS];
    logic [TAG_W-1:0]    tag_q   [NUM_WAYS][NUM_SETS];
    logic [NUM_SETS-1:0] valid_q [NUM_WAYS];
    logic [NUM_SETS-1:0] lru_q;   // way to evict next

    logic [NUM_WAYS-1:0] way_hit;
    logic                is_idle, hit, hit_way, fill_done, fill_hit, access, acc_way;
    logic                fill_wr, mem_we;
    logic [OFFSET_W-1:0] fill_word;
    logic [MAW-1:0]      mem_addr;
    logic [DWIDTH-1:0]   mem_rdata, rdata_sel;

    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
        assign way_hit[gi] = valid_q[gi][idx_w] && (tag_q[gi][idx_w] == tag_w);
    end

    assign is_idle   = (state_q == IDLE);
    assign hit       = mem_en && is_idle && (|way_hit);
    assign hit_way   = way_hit[1];
    assign fill_done = (state_q == FILL) && (cnt_q == 4'(FILL_LAST));
    // The held access completes in the last fill cycle, alongside word 7.
    assign fill_hit  = fill_done && mem_en && (tag_w == fill_tag_q) && (idx_w == fill_idx_q);
    assign access    = hit || fill_hit;
    assign acc_way   = fill_hit ? victim_q : hit_way;
    assign fill_wr   = (state_q == FILL) && (cnt_q >= 4'(MEM_LATENCY));
    assign fill_word = OFFSET_W'(cnt_q - 4'(MEM_LATENCY));
    assign mem_we    = access && mem_write;

    always_comb begin
        mem_addr = {tag_w, idx_w, off_w};
        if ((state_q == FILL) && (cnt_q < 4'(BLOCK_WORDS))) begin
            mem_addr = {fill_tag_q, fill_idx_q, cnt_q[OFFSET_W-1:0]};
        end
    end

    // Word 7 is not in the array yet during the last fill cycle.
    assign rdata_sel = (fill_hit && (off_w == OFFSET_W'(BLOCK_WORDS - 1)))
                     ? mem_rdata : data_q[acc_way][{idx_w, off_w}];
    assign data_out  = (access && !mem_write) ? rdata_sel : '0;
    assign cache_miss_stall = (is_idle && mem_en && !hit)
                            || ((state_q == FILL) && !fill_done)
                            || (fill_done && mem_en && !fill_hit);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_tag_d = fill_tag_q;
        fill_idx_d = fill_idx_q;
        victim_d   = victim_q;
        case (state_q)
            IDLE: begin
                if (mem_en && !hit) begin
                    state_d    = FILL;
                    cnt_d      = '0;
                    fill_tag_d = tag_w;
                    fill_idx_d = idx_w;
                    victim_d   = !valid_q[0][idx_w] ? 1'b0
                               : (!valid_q[1][idx_w] ? 1'b1 : lru_q[idx_w]);
                end
            end
            FILL: begin
                cnt_d = cnt_q + 4'd1;
                if (fill_done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            fill_tag_q <= '0;
            fill_idx_q <= '0;
            victim_q   <= 1'b0;
            lru_q      <= '0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                valid_q[w] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_tag_q <= fill_tag_d;
            fill_idx_q <= fill_idx_d;
            victim_q   <= victim_d;
            if (hit) begin
                lru_q[idx_w] <= ~hit_way;
            end
            if (fill_done) begin
                valid_q[victim_q][fill_idx_q] <= 1'b1;
                lru_q[fill_idx_q]             <= ~victim_q;
            end
        end
    end

    // Access write follows the fill write so it wins on the same word.
    always_ff @(posedge clk) begin
        if (fill_wr) begin
            data_q[victim_q][{fill_idx_q, fill_word}] <= mem_rdata;
        end
        if (access && mem_write) begin
            data_q[acc_way][{idx_w, off_w}] <= data_in;
        end
        if (fill_done) begin
            tag_q[victim_q][fill_idx_q] <= fill_tag_q;
        end
    end

    main_memory #(
        .DWIDTH    (DWIDTH),
        .MEM_WORDS (MEM_WORDS),
        .MAW       (MAW)
    ) u_main_memory (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (data_in),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_memory_system.sv
// Directed bench for memory_system: miss/hit timing, write-through,
// LRU eviction, block fill contents and reset during a fill.
module tb_memory_system;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic        mem_write;
    logic [15:0] addr_in;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        cache_miss_stall;

    int checks = 0;
    int fails  = 0;

    memory_system dut (
        .clk              (clk),
        .rst              (rst),
        .mem_en           (mem_en),
        .mem_write        (mem_write),
        .addr_in          (addr_in),
        .data_in          (data_in),
        .data_out         (data_out),
        .cache_miss_stall (cache_miss_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; holds the access until stall drops,
    // checks the stall length and the data returned in the completing cycle.
    task automatic do_access(input logic wr, input logic [15:0] a, input logic [15:0] d,
                             input int exp_stall, input logic [15:0] exp_out, input string tag);
        int n;
        n = 0;
        mem_en    = 1'b1;
        mem_write = wr;
        addr_in   = a;
        data_in   = d;
        #1;
        if (exp_stall > 0) chk($sformatf("%s detect data_out", tag), 32'(data_out), 32'h0);
        while (cache_miss_stall && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk($sformatf("%s stall cycles", tag), 32'(n), 32'(exp_stall));
        chk($sformatf("%s data_out", tag), 32'(data_out), 32'(exp_out));
        $display("access %s wr=%0d addr=%04h stall=%0d data_out=%04h", tag, wr, a, n, data_out);
        @(posedge clk);
        #1;
        mem_en    = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] blk_val [8];
        for (int k = 0; k < 8; k++) blk_val[k] = 16'h1000 + 16'(k) * 16'h0111;

        rst = 1'b1; mem_en = 1'b0; mem_write = 1'b0; addr_in = '0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset stall", 32'(cache_miss_stall), 32'h0);
        chk("reset data_out", 32'(data_out), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Cold read only probes the miss; mem_en drops before the edge.
        mem_en = 1'b1; addr_in = 16'h0000;
        #1;
        chk("cold read stall", 32'(cache_miss_stall), 32'h1);
        chk("cold read data_out", 32'(data_out), 32'h0);
        mem_en = 1'b0;
        #1;
        chk("idle stall", 32'(cache_miss_stall), 32'h0);
        @(posedge clk);
        #1;

        do_access(1'b1, 16'h0000, 16'hABCD, 12, 16'h0000, "wmiss 0000");
        do_access(1'b0, 16'h0000, 16'h0000, 0,  16'hABCD, "rhit 0000");
        do_access(1'b1, 16'h0100, 16'hFF00, 12, 16'h0000, "wmiss 0100");
        do_access(1'b0, 16'h0000, 16'h0000, 0,  16'hABCD, "rhit 0000 b");
        do_access(1'b0, 16'h0100, 16'h0000, 0,  16'hFF00, "rhit 0100");

        // Set 0 conflicts and LRU.
        do_access(1'b1, 16'h0200, 16'h5A5A, 12, 16'h0000, "wmiss 0200");
        do_access(1'b0, 16'h0000, 16'h0000, 0,  16'hABCD, "rhit 0000 c");
        do_access(1'b0, 16'h0400, 16'h0000, 12, 16'h0000, "rmiss 0400");
        do_access(1'b0, 16'h0000, 16'h0000, 0,  16'hABCD, "rhit 0000 d");
        do_access(1'b0, 16'h0200, 16'h0000, 12, 16'h5A5A, "rmiss 0200");
        do_access(1'b0, 16'h0000, 16'h0000, 0,  16'hABCD, "rhit 0000 e");

        // Block fill: one write miss then seven write hits.
        for (int k = 0; k < 8; k++) begin
            do_access(1'b1, 16'h0A00 + 16'(2*k), blk_val[k], (k == 0) ? 12 : 0, 16'h0000,
                      $sformatf("wblk %0d", k));
        end
        do_access(1'b0, 16'h0C00, 16'h0000, 12, 16'h0000, "rmiss 0C00");
        do_access(1'b0, 16'h0E00, 16'h0000, 12, 16'h0000, "rmiss 0E00");
        // Last word first: its data is forwarded straight from memory.
        for (int k = 7; k >= 0; k--) begin
            do_access(1'b0, 16'h0A00 + 16'(2*k), 16'h0000, (k == 7) ? 12 : 0, blk_val[k],
                      $sformatf("rblk %0d", k));
        end

        // Set 16: write-allocate on word 7, then evict that block.
        do_access(1'b1, 16'h030E, 16'h1234, 12, 16'h0000, "wmiss 030E");
        do_access(1'b0, 16'h030E, 16'h0000, 0,  16'h1234, "rhit 030E");
        do_access(1'b0, 16'h0500, 16'h0000, 12, 16'h0000, "rmiss 0500");
        do_access(1'b0, 16'h0700, 16'h0000, 12, 16'h0000, "rmiss 0700");

        // Reset during fill cycle 5 of a miss on 0x030E.
        mem_en = 1'b1; mem_write = 1'b0; addr_in = 16'h030E;
        #1;
        chk("abort detect stall", 32'(cache_miss_stall), 32'h1);
        repeat (6) @(posedge clk);
        #1;
        chk("abort fill5 stall", 32'(cache_miss_stall), 32'h1);
        rst = 1'b1; mem_en = 1'b0;
        @(posedge clk);
        #1;
        chk("abort reset stall", 32'(cache_miss_stall), 32'h0);
        chk("abort reset data_out", 32'(data_out), 32'h0);
        $display("reset during fill: stall=%0d data_out=%04h", cache_miss_stall, data_out);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_access(1'b0, 16'h030E, 16'h0000, 12, 16'h1234, "post-reset 030E");
        do_access(1'b0, 16'h0A0C, 16'h0000, 12, blk_val[6], "post-reset 0A0C");
        do_access(1'b0, 16'h0A04, 16'h0000, 0,  blk_val[2], "post-reset 0A04");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
